// File: rtl/mtm_alu_pkg.sv
// Shared definitions for the ALU input link receiver: OP codes, error flag
// positions, CRC-4 polynomial and frame geometry.
package mtm_alu_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b101;

  // Bit positions inside err_flags = {ERR_DATA, ERR_CRC, ERR_OP}
  localparam int ERR_DATA = 2;
  localparam int ERR_CRC  = 1;
  localparam int ERR_OP   = 0;

  localparam logic [3:0] CRC4_POLY = 4'b0011;
  localparam int         FRAME_LEN = 11;

  typedef enum logic [1:0] {
    FR_IDLE,
    FR_TYPE,
    FR_BITS,
    FR_STOP
  } frame_state_t;

  // One serial step of CRC-4 (x^4+x+1), MSB first
  function automatic logic [3:0] crc4_step(input logic [3:0] crc, input logic d);
    logic fb;
    fb = crc[3] ^ d;
    return {crc[2:0], 1'b0} ^ (fb ? CRC4_POLY : 4'b0000);
  endfunction

  function automatic logic op_valid(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/mtm_alu_rx_frame.sv
// Bit-level frame receiver: start(0), type, 8 payload bits MSB first, stop(1).
// Emits a one-cycle frame_ok or frame_err pulse the cycle after the stop bit.
module mtm_alu_rx_frame
  import mtm_alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sin,
  output logic [7:0] rx_byte,
  output logic       is_ctl,
  output logic       frame_ok,
  output logic       frame_err,
  output logic       idle
);

  localparam int PAYLOAD_BITS = FRAME_LEN - 3;

  frame_state_t state;
  logic [2:0]   bit_cnt;

  assign idle = (state == FR_IDLE);

  // Frame FSM: walks start/type/payload/stop and flags the stop-bit outcome
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FR_IDLE;
      bit_cnt   <= 3'd0;
      rx_byte   <= 8'd0;
      is_ctl    <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      case (state)
        FR_IDLE: if (!sin) state <= FR_TYPE;
        FR_TYPE: begin
          is_ctl  <= sin;
          bit_cnt <= 3'd0;
          state   <= FR_BITS;
        end
        FR_BITS: begin
          rx_byte <= {rx_byte[6:0], sin};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'(PAYLOAD_BITS - 1)) state <= FR_STOP;
        end
        FR_STOP: begin
          if (sin) frame_ok  <= 1'b1;
          else     frame_err <= 1'b1;
          state <= FR_IDLE;
        end
        default: state <= FR_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/mtm_alu_rx_deser.sv
// ALU input link receiver: assembles two DATA_W operands from DATA frames,
// checks length / CRC-4 / OP on the CTL frame and presents a command or an
// error over valid/ready. Optional input synchronizer: MTM_ALU_RX_SYNC_EN.
module mtm_alu_rx_deser
  import mtm_alu_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 1024,
  parameter int OVF_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_a,
  output logic [DATA_W-1:0] out_b,
  output logic [2:0]        out_op,
  output logic              out_err,
  output logic [2:0]        err_flags,
  output logic [OVF_W-1:0]  ovf_cnt
);

  localparam int NB = 2 * DATA_W / 8;
  localparam int CW = $clog2(NB + 2);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] NB_C     = CW'(NB);
  localparam logic [CW-1:0] NB_SAT   = CW'(NB + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  logic sin_s;

`ifdef MTM_ALU_RX_SYNC_EN
  logic [1:0] sync_q;
  // Two-flop synchronizer, idles high like the line itself
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], sin};
  end
  assign sin_s = sync_q[1];
`else
  assign sin_s = sin;
`endif

  logic [7:0] rx_byte;
  logic       is_ctl, frame_ok, frame_err, frm_idle;

  mtm_alu_rx_frame u_frame (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin_s),
    .rx_byte   (rx_byte),
    .is_ctl    (is_ctl),
    .frame_ok  (frame_ok),
    .frame_err (frame_err),
    .idle      (frm_idle)
  );

  function automatic logic [3:0] crc4_byte(input logic [3:0] c, input logic [7:0] b);
    logic [3:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) r = crc4_step(r, b[i]);
    return r;
  endfunction

  logic [CW-1:0]       byte_cnt;
  logic [3:0]          crc_q;
  logic [TW-1:0]       tmo_cnt;
  logic [2*DATA_W-1:0] opnd;
  logic                data_ok, ctl_ok, tmo_run, tmo_hit;
  logic [2:0]          ctl_op;
  logic [3:0]          ctl_crc, crc_final;
  logic [2:0]          flags;

  assign data_ok = frame_ok && !is_ctl;
  assign ctl_ok  = frame_ok && is_ctl;
  assign ctl_op  = rx_byte[6:4];
  assign ctl_crc = rx_byte[3:0];
  // Trailer of the CRC stream: a constant 1 followed by the OP bits
  assign crc_final = crc4_step(crc4_step(crc4_step(crc4_step(crc_q, 1'b1),
                     ctl_op[2]), ctl_op[1]), ctl_op[0]);

  // Idle time only accrues between frames of a started packet
  assign tmo_run = frm_idle && sin_s && (byte_cnt != '0);
  assign tmo_hit = tmo_run && (tmo_cnt == TMO_LAST);

  // Packet checks; priority gives exactly one flag per error packet
  always_comb begin
    flags = 3'b000;
    if (byte_cnt != NB_C)          flags[ERR_DATA] = 1'b1;
    else if (crc_final != ctl_crc) flags[ERR_CRC]  = 1'b1;
    else if (!op_valid(ctl_op))    flags[ERR_OP]   = 1'b1;
  end

  // Packet byte count and running CRC; cleared on packet end or discard
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      crc_q    <= 4'd0;
    end else if (frame_err || ctl_ok || tmo_hit) begin
      byte_cnt <= '0;
      crc_q    <= 4'd0;
    end else if (data_ok && (byte_cnt != NB_SAT)) begin
      byte_cnt <= byte_cnt + CW'(1);
      if (byte_cnt < NB_C) crc_q <= crc4_byte(crc_q, rx_byte);
    end
  end

  // Mid-packet idle timer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 tmo_cnt <= '0;
    else if (!tmo_run || tmo_hit) tmo_cnt <= '0;
    else                        tmo_cnt <= tmo_cnt + TW'(1);
  end

  // Operand shifter {A,B}; bytes past NB leave it untouched
  always_ff @(posedge clk) begin
    if (data_ok && (byte_cnt < NB_C)) opnd <= {opnd[2*DATA_W-9:0], rx_byte};
  end

  // Result register with hold-until-accept and drop counting
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_a     <= '0;
      out_b     <= '0;
      out_op    <= 3'd0;
      out_err   <= 1'b0;
      err_flags <= 3'd0;
      ovf_cnt   <= '0;
    end else if (ctl_ok) begin
      if (!out_valid || out_ready) begin
        out_valid <= 1'b1;
        out_a     <= opnd[2*DATA_W-1:DATA_W];
        out_b     <= opnd[DATA_W-1:0];
        out_op    <= ctl_op;
        out_err   <= |flags;
        err_flags <= flags;
      end else if (ovf_cnt != '1) begin
        ovf_cnt <= ovf_cnt + OVF_W'(1);
      end
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mtm_alu_rx_deser.sv
// Self-checking bench for mtm_alu_rx_deser: directed scenarios plus random
// packets against a queue-based reference model.
module tb_mtm_alu_rx_deser;

  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 40;
  localparam int OVF_W   = 8;
  localparam int NB      = 2 * DATA_W / 8;
`ifdef MTM_ALU_RX_SYNC_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 1;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              sin = 1'b1;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [DATA_W-1:0] out_a, out_b;
  logic [2:0]        out_op;
  logic              out_err;
  logic [2:0]        err_flags;
  logic [OVF_W-1:0]  ovf_cnt;

  always #5 clk = ~clk;

  mtm_alu_rx_deser #(.DATA_W(DATA_W), .TIMEOUT(TIMEOUT), .OVF_W(OVF_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sin       (sin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_a     (out_a),
    .out_b     (out_b),
    .out_op    (out_op),
    .out_err   (out_err),
    .err_flags (err_flags),
    .ovf_cnt   (ovf_cnt)
  );

  typedef struct {
    logic              err;
    logic [2:0]        flags;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [2:0]        op;
  } exp_t;

  exp_t expq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   ovf_exp = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // CRC as polynomial remainder of (message * x^4) mod (x^4+x+1)
  function automatic logic [3:0] crc_ref(input logic [DATA_W-1:0] a,
                                         input logic [DATA_W-1:0] b,
                                         input logic [2:0] op);
    logic [2*DATA_W+7:0] v;
    v = {a, b, 1'b1, op, 4'b0000};
    for (int i = 2*DATA_W+7; i >= 4; i--)
      if (v[i]) v[i-:5] = v[i-:5] ^ 5'b10011;
    return v[3:0];
  endfunction

  // Consumer side: every accepted result must be the next expected one
  always @(negedge clk) begin
    #1;
    if (rst_n && out_valid && out_ready) begin
      if (expq.size() == 0) begin
        check("unexpected_result", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = expq.pop_front();
        check("out_err", 64'(out_err), 64'(e.err));
        check("err_flags", 64'(err_flags), 64'(e.flags));
        if (!e.err) begin
          check("out_a", 64'(out_a), 64'(e.a));
          check("out_b", 64'(out_b), 64'(e.b));
          check("out_op", 64'(out_op), 64'(e.op));
        end
      end
    end
  end

  task automatic bit_out(input logic v);
    @(negedge clk);
    sin = v;
  endtask

  task automatic idle(input int n);
    repeat (n) bit_out(1'b1);
  endtask

  task automatic send_frame(input logic ctl, input logic [7:0] b, input logic stop);
    bit_out(1'b0);
    bit_out(ctl);
    for (int i = 7; i >= 0; i--) bit_out(b[i]);
    bit_out(stop);
  endtask

  task automatic send_pkt(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                          input logic [2:0] op, input int ndata,
                          input logic bad_crc, input logic deliver);
    logic [2*DATA_W-1:0] ab;
    logic [3:0]          c;
    logic [7:0]          d;
    exp_t                e;
    ab = {a, b};
    for (int i = 0; i < ndata; i++) begin
      if (i < NB) d = ab[2*DATA_W-1-8*i -: 8];
      else        d = 8'($urandom);
      send_frame(1'b0, d, 1'b1);
      idle($urandom_range(0, 3));
    end
    c = crc_ref(a, b, op);
    if (bad_crc) c = ~c;
    e.a = a; e.b = b; e.op = op; e.err = 1'b1;
    if (ndata != NB)   e.flags = 3'b100;
    else if (bad_crc)  e.flags = 3'b010;
    else if (!(op == 3'b000 || op == 3'b001 || op == 3'b100 || op == 3'b101))
                       e.flags = 3'b001;
    else begin
      e.flags = 3'b000;
      e.err   = 1'b0;
    end
    if (deliver) expq.push_back(e);
    else         ovf_exp++;
    send_frame(1'b1, {1'b0, op, c}, 1'b1);
    if (deliver && out_ready) begin
      repeat (LAT) bit_out(1'b1);
      check("latency_early", 64'(out_valid), 64'd0);
      bit_out(1'b1);
      check("latency_valid", 64'(out_valid), 64'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_a"}, 64'(out_a), 64'd0);
    check({tag, "_b"}, 64'(out_b), 64'd0);
    check({tag, "_op"}, 64'(out_op), 64'd0);
    check({tag, "_err"}, 64'(out_err), 64'd0);
    check({tag, "_flags"}, 64'(err_flags), 64'd0);
    check({tag, "_ovf"}, 64'(ovf_cnt), 64'd0);
  endtask

  initial begin
    logic [DATA_W-1:0] ra, rb, p1a, p1b;
    logic [2:0]        rop;
    int                r, nd;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    out_ready = 1'b1;
    idle(5);

    // Max A + 1 as ADD with good CRC
    send_pkt(32'hFFFF_FFFF, 32'h0000_0001, 3'b100, NB, 1'b0, 1'b1);
    idle(4);
    // Corrupted CRC
    send_pkt(32'd5, 32'd2, 3'b100, NB, 1'b1, 1'b1);
    idle(4);
    // Short packet, then recovery
    send_pkt(32'($urandom), 32'($urandom), 3'b000, 2, 1'b0, 1'b1);
    idle(2);
    send_pkt(32'h1234_5678, 32'h9ABC_DEF0, 3'b101, NB, 1'b0, 1'b1);
    idle(2);
    // Unsupported OP
    send_pkt(32'd10, 32'd10, 3'b010, NB, 1'b0, 1'b1);
    // Empty packet
    send_pkt(32'd0, 32'd0, 3'b000, 0, 1'b0, 1'b1);
    idle(3);

    // Stalled consumer: second result dropped, first held
    out_ready = 1'b0;
    p1a = 32'($urandom); p1b = 32'($urandom);
    send_pkt(p1a, p1b, 3'b001, NB, 1'b0, 1'b1);
    idle(LAT + 2);
    check("stall_valid", 64'(out_valid), 64'd1);
    send_pkt(32'($urandom), 32'($urandom), 3'b100, NB, 1'b0, 1'b0);
    idle(LAT + 3);
    check("hold_valid", 64'(out_valid), 64'd1);
    check("hold_a", 64'(out_a), 64'(p1a));
    check("hold_b", 64'(out_b), 64'(p1b));
    check("hold_op", 64'(out_op), 64'd1);
    check("ovf_cnt", 64'(ovf_cnt), 64'(ovf_exp));
    out_ready = 1'b1;
    bit_out(1'b1);
    check("valid_drop", 64'(out_valid), 64'd0);
    idle(3);

    // Partial packet abandoned by timeout
    for (int i = 0; i < 3; i++) send_frame(1'b0, 8'($urandom), 1'b1);
    idle(TIMEOUT + 10);
    send_pkt(32'hCAFE_0001, 32'h0000_BEEF, 3'b100, NB, 1'b0, 1'b1);
    idle(3);

    // Framing error mid-packet
    for (int i = 0; i < 3; i++) send_frame(1'b0, 8'($urandom), 1'b1);
    send_frame(1'b0, 8'($urandom), 1'b0);
    idle(2);
    send_pkt(32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'b000, NB, 1'b0, 1'b1);
    idle(3);

    // Reset pulsed in the middle of a frame
    for (int i = 0; i < 2; i++) send_frame(1'b0, 8'($urandom), 1'b1);
    bit_out(1'b0); bit_out(1'b0); bit_out(1'b1); bit_out(1'b0);
    #2 rst_n = 1'b0;
    sin = 1'b1;
    ovf_exp = 0;
    @(negedge clk);
    check_reset_outputs("midreset");
    rst_n = 1'b1;
    idle(3);
    send_pkt(32'h8000_0000, 32'h7FFF_FFFF, 3'b101, NB, 1'b0, 1'b1);
    idle(3);

    // Random packets
    for (int k = 0; k < 25; k++) begin
      ra  = 32'($urandom);
      rb  = 32'($urandom);
      rop = 3'($urandom_range(0, 7));
      r   = $urandom_range(0, 9);
      nd  = (r == 0) ? $urandom_range(0, NB + 2) : NB;
      send_pkt(ra, rb, rop, nd, r == 1, 1'b1);
      idle($urandom_range(0, 2));
    end

    idle(10);
    check("queue_drained", 64'(expq.size()), 64'd0);
    check("final_ovf", 64'(ovf_cnt), 64'(ovf_exp));
    check("final_valid", 64'(out_valid), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
